// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the second fetch stage.
//               fe1_entry_t is one instruction-buffer slot: the PC of the
//               request, the returned instruction word and its fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef struct packed {
        logic [31:2] pc;
        logic [31:0] insn;
        logic        fault;
    } fe1_entry_t;

    // A faulting fetch carries no usable instruction bits.
    localparam logic [31:0] FE1_FAULT_INSN = 32'h0;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_ibuf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ibuf
// Description : DEPTH-entry in-order instruction FIFO with synchronous flush.
//               Pointers wrap at DEPTH-1, so DEPTH need not be a power of two.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push/push_entry - write one entry at the tail
//               pop             - retire the head (ignored when empty)
//               flush           - empty the buffer next cycle (wins over all)
//               count           - current occupancy
//               head            - entry at the read pointer
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fe1_entry_t    push_entry,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fe1_entry_t    head
);

    fe1_entry_t    mem_q [DEPTH];
    fe1_entry_t    mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule : fetch_ibuf
`default_nettype wire

// File: rtl/stage_fetch1.sv
`default_nettype none
// ============================================================================
// Module      : stage_fetch1
// Description : Second fetch stage. Tracks the single outstanding icache
//               request, buffers responses in order and presents the head
//               to decode. Redirects flush the buffer and drop in-flight data.
// Ports       : clk_core, reset_n          - clock, async active-low reset
//               fe0_valid, fe0_read_addr   - request issued by fetch0
//               fe1_stall                  - fetch0 must hold off
//               icache_ready/data/fault    - response to latest request
//               de_stall                   - decode backpressure
//               de_setpc, csr_kill_setpc   - redirect (flush)
//               fe1_valid/insn/pc/fault    - buffer head to decode
// Revision    : 1.0 - initial release
// ============================================================================
module stage_fetch1
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        fe0_valid,
    input  logic [31:2] fe0_read_addr,
    output logic        fe1_stall,
    input  logic        icache_ready,
    input  logic [31:0] icache_data,
    input  logic        icache_fault,
    input  logic        de_stall,
    input  logic        de_setpc,
    input  logic        csr_kill_setpc,
    output logic        fe1_valid,
    output logic [31:0] fe1_insn,
    output logic [31:2] fe1_pc,
    output logic        fe1_fault
);

    localparam int CW = $clog2(DEPTH + 1);

    logic          pend_q,    pend_d;
    logic [31:2]   pend_pc_q, pend_pc_d;
    fe1_entry_t    hold_q,    hold_d;

    logic          flush;
    logic          push;
    logic          pop;
    fe1_entry_t    push_entry;
    fe1_entry_t    head;
    logic [CW-1:0] count;
    logic [CW:0]   occ;

    assign flush     = de_setpc | csr_kill_setpc;
    assign fe1_valid = (count != '0);
    assign pop       = fe1_valid & ~de_stall;
    // A ready in the same cycle as a new request still answers the older
    // request, so it is pushed unless a redirect is discarding it.
    assign push      = pend_q & icache_ready & ~flush;

    always_comb begin
        push_entry.pc    = pend_pc_q;
        push_entry.insn  = icache_fault ? FE1_FAULT_INSN : icache_data;
        push_entry.fault = icache_fault;
    end

    // Occupancy after this cycle's pop, counting the outstanding request as
    // a reserved slot so a later push can never find the buffer full.
    always_comb begin
        occ       = {1'b0, count} + {{CW{1'b0}}, pend_q} - {{CW{1'b0}}, pop};
        fe1_stall = (pend_q & ~icache_ready) | (occ >= (CW+1)'(DEPTH));
    end

    always_comb begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (fe0_valid) begin
            pend_d    = 1'b1;
            pend_pc_d = fe0_read_addr;
        end else if (flush) begin
            pend_d    = 1'b0;
        end else if (pend_q && icache_ready) begin
            pend_d    = 1'b0;
        end
    end

    // Outputs follow the head while valid and freeze on the last presented
    // entry once the buffer drains.
    always_comb begin
        hold_d = fe1_valid ? head : hold_q;
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            hold_q    <= '0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            hold_q    <= hold_d;
        end
    end

    assign fe1_insn  = hold_d.insn;
    assign fe1_pc    = hold_d.pc;
    assign fe1_fault = hold_d.fault;

    fetch_ibuf #(
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk        (clk_core),
        .rst_n      (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .count      (count),
        .head       (head)
    );

endmodule : stage_fetch1
`default_nettype wire
